// File: rtl/golomb_limit_decoder.sv
// golomb_limit_decoder
//   Bit-serial reader for JPEG-LS regular-mode Golomb codes, including the LIMIT escape form.
//   Byte-packed scan data (MSB first, 0xFF bit-stuffing) fills a left-aligned bit buffer.
//   The FSM consumes one bit per cycle and rebuilds MErrval = (q << k) | rem. In escape form
//   (MAXQ zeros, a '1', then QBPP bits) MErrval = field + 1.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_byte_in/_valid    scan byte source; o_byte_ready when the buffer has room for 8 bits
//   i_flush             empty buffer, clear 0xFF history, abort decode
//   i_k_in, i_sym_req   Golomb k and symbol request (honoured only in IDLE)
//   o_sym_busy          decode in progress
//   o_merrval           decoded value, held until the next symbol completes
//   o_merrval_valid     one-cycle pulse with o_merrval/o_escape update
//   o_escape            last symbol used the escape form
//   o_code_err          pulse: '0' where the escape terminator '1' was required
//   o_stuff_err         pulse: byte following 0xFF had its MSB set
module golomb_limit_decoder #(
  parameter int unsigned LIMIT  = 32,
  parameter int unsigned QBPP   = 8,
  parameter int unsigned BUF_W  = 32,
  parameter int unsigned MERR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  input  logic              i_flush,
  input  logic [3:0]        i_k_in,
  input  logic              i_sym_req,
  output logic              o_sym_busy,
  output logic [MERR_W-1:0] o_merrval,
  output logic              o_merrval_valid,
  output logic              o_escape,
  output logic              o_code_err,
  output logic              o_stuff_err
);

  localparam int unsigned MaxQ = LIMIT - QBPP - 1;
  localparam int unsigned CntW = $clog2(BUF_W + 1);

  typedef enum logic [2:0] {StIdle, StUnary, StRem, StEscB, StEsc, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [BUF_W-1:0]  r_buf;
  logic [CntW-1:0]   r_cnt;
  logic              r_ff;
  logic [7:0]        r_q;
  logic [MERR_W-1:0] r_rem;
  logic [4:0]        r_j;
  logic [3:0]        r_k;
  logic              r_esc;
  logic [MERR_W-1:0] r_merrval;
  logic              r_escape_out;
  logic              r_stuff_err;

  logic              w_decoding, w_consume, w_bit, w_accept;
  logic [CntW-1:0]   w_cnt_after, w_add;
  logic [BUF_W-1:0]  w_buf_after, w_new_al;
  logic [MERR_W-1:0] w_result;

  assign o_byte_ready = (r_cnt <= CntW'(BUF_W - 8));
  assign w_decoding   = (r_state == StUnary) || (r_state == StRem) ||
                        (r_state == StEscB)  || (r_state == StEsc);
  assign w_consume    = w_decoding && (r_cnt != '0) && !i_flush;
  assign w_bit        = r_buf[BUF_W-1];
  assign w_accept     = i_byte_valid && o_byte_ready && !i_flush;

  // After a 0xFF byte the stuffed MSB is dropped; new bits land right after the valid ones.
  assign w_cnt_after  = r_cnt - CntW'(w_consume);
  assign w_buf_after  = w_consume ? (r_buf << 1) : r_buf;
  assign w_new_al     = r_ff ? {i_byte_in[6:0], {(BUF_W-7){1'b0}}}
                             : {i_byte_in, {(BUF_W-8){1'b0}}};
  assign w_add        = r_ff ? CntW'(7) : CntW'(8);

  assign w_result = r_esc ? (r_rem + MERR_W'(1))
                          : ((MERR_W'(r_q) << r_k) | r_rem);

  // Bit buffer and 0xFF history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_ff        <= 1'b0;
      r_stuff_err <= 1'b0;
    end else if (i_flush) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_ff        <= 1'b0;
      r_stuff_err <= 1'b0;
    end else begin
      r_buf       <= w_buf_after | (w_accept ? (w_new_al >> w_cnt_after) : '0);
      r_cnt       <= w_cnt_after + (w_accept ? w_add : '0);
      if (w_accept) r_ff <= (i_byte_in == 8'hFF);
      r_stuff_err <= w_accept && r_ff && i_byte_in[7];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM next state; every decoding state stalls while the buffer is empty
  always_comb begin
    w_state_d = r_state;
    if (i_flush) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (i_sym_req) w_state_d = StUnary;
        StUnary: begin
          if (w_consume) begin
            if (w_bit)                      w_state_d = (r_k == '0) ? StDone : StRem;
            else if (r_q == 8'(MaxQ - 1))   w_state_d = StEscB;
          end
        end
        StRem:   if (w_consume && r_j == 5'd1) w_state_d = StDone;
        StEscB:  if (w_consume) w_state_d = w_bit ? StEsc : StIdle;
        StEsc:   if (w_consume && r_j == 5'd1) w_state_d = StDone;
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Symbol datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= '0;
      r_rem        <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_esc        <= 1'b0;
      r_merrval    <= '0;
      r_escape_out <= 1'b0;
    end else if (!i_flush) begin
      unique case (r_state)
        StIdle: begin
          if (i_sym_req) begin
            r_k   <= i_k_in;
            r_q   <= '0;
            r_rem <= '0;
            r_esc <= 1'b0;
          end
        end
        StUnary: begin
          if (w_consume) begin
            if (!w_bit) r_q <= r_q + 8'd1;
            else        r_j <= {1'b0, r_k};
          end
        end
        StRem, StEsc: begin
          if (w_consume) begin
            r_rem <= {r_rem[MERR_W-2:0], w_bit};
            r_j   <= r_j - 5'd1;
          end
        end
        StEscB: begin
          if (w_consume && w_bit) begin
            r_j   <= 5'(QBPP);
            r_esc <= 1'b1;
          end
        end
        StDone: begin
          r_merrval    <= w_result;
          r_escape_out <= r_esc;
        end
        default: ;
      endcase
    end
  end

  // Outputs; the DONE cycle shows the fresh result before it lands in the hold registers
  always_comb begin
    o_sym_busy      = (r_state != StIdle);
    o_merrval_valid = (r_state == StDone) && !i_flush;
    o_merrval       = o_merrval_valid ? w_result : r_merrval;
    o_escape        = o_merrval_valid ? r_esc : r_escape_out;
    o_code_err      = (r_state == StEscB) && w_consume && !w_bit;
    o_stuff_err     = r_stuff_err;
  end

endmodule
